// File: rtl/alu_op_controller.sv
// Front-panel controller: debounced mode/start buttons drive a one-at-a-time ALU request and result capture.
// Latency: start press -> op_valid after 2 cycles (LATCH, ISSUE); result visible one cycle after res_valid.
// Backpressure: op_valid holds with A/B/mode stable until op_ready; button events outside IDLE are dropped.
module alu_op_controller #(
    parameter int N         = 4,
    parameter int NUM_MODES = 10,
    parameter int DEBOUNCE  = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         selector,
    input  logic         start,
    input  logic [N-1:0] A_sw,
    input  logic [N-1:0] B_sw,
    output logic [3:0]   mode,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic         op_valid,
    input  logic         op_ready,
    input  logic         res_valid,
    input  logic [N-1:0] res_data,
    input  logic [3:0]   res_flags,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic         busy,
    output logic         timeout_err,
    output logic [7:0]   op_count
);
    localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_ISSUE, S_WAIT, S_SHOW} state_t;

    // Button lanes: bit 0 = selector, bit 1 = start.
    logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]          db_q, db_d, ev_q, ev_d;
    logic [1:0][DBW-1:0] dbc_q, dbc_d;

    state_t         state_q, state_d;
    logic [3:0]     mode_q, mode_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
    logic [3:0]     flags_q, flags_d;
    logic           err_q, err_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [TW-1:0]  tmr_q, tmr_d;

    logic sel_ev, st_ev;

    always_comb begin
        sync1_d = {start, selector};
        sync2_d = sync1_q;
        db_d    = db_q;
        dbc_d   = dbc_q;
        ev_d    = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                dbc_d[i] = '0;
            end else if (dbc_q[i] == DBW'(DEBOUNCE - 1)) begin
                // Level accepted: a released->pressed flip is the one press event.
                dbc_d[i] = '0;
                db_d[i]  = sync2_q[i];
                ev_d[i]  = db_q[i];
            end else begin
                dbc_d[i] = dbc_q[i] + DBW'(1);
            end
        end
    end

    assign sel_ev = ev_q[0];
    assign st_ev  = ev_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            db_q    <= 2'b11;
            dbc_q   <= '0;
            ev_q    <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            dbc_q   <= dbc_d;
            ev_q    <= ev_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        case (state_q)
            S_IDLE: begin
                if (st_ev) begin
                    err_d   = 1'b0;
                    state_d = S_LATCH;
                end else if (sel_ev) begin
                    mode_d = (mode_q == 4'(NUM_MODES - 1)) ? 4'd0 : mode_q + 4'd1;
                end
            end
            S_LATCH: begin
                a_d     = A_sw;
                b_d     = B_sw;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (op_ready) begin
                    tmr_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result arriving in the final timer cycle still beats the abort.
                if (res_valid) begin
                    result_d = res_data;
                    flags_d  = res_flags;
                    state_d  = S_SHOW;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_SHOW: begin
                cnt_d   = cnt_q + 8'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
        end
    end

    assign mode        = mode_q;
    assign A           = a_q;
    assign B           = b_q;
    assign result      = result_q;
    assign flags       = flags_q;
    assign timeout_err = err_q;
    assign op_count    = cnt_q;
    assign op_valid    = (state_q == S_ISSUE);
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_op_controller.sv
// Scoreboard bench: stimulus pushes expected mode changes, issued requests and completions;
// an independent monitor pops and compares whenever the controller presents them.
module tb_alu_op_controller;
    localparam int N         = 4;
    localparam int NUM_MODES = 10;
    localparam int DEBOUNCE  = 4;
    localparam int TIMEOUT   = 16;

    logic         clk = 1'b0;
    logic         reset, selector, start, op_ready, res_valid;
    logic [N-1:0] A_sw, B_sw, res_data;
    logic [3:0]   res_flags;
    logic [3:0]   mode, flags;
    logic [N-1:0] A, B, result;
    logic         op_valid, busy, timeout_err;
    logic [7:0]   op_count;

    alu_op_controller #(.N(N), .NUM_MODES(NUM_MODES), .DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .selector(selector), .start(start),
        .A_sw(A_sw), .B_sw(B_sw), .mode(mode), .A(A), .B(B),
        .op_valid(op_valid), .op_ready(op_ready), .res_valid(res_valid),
        .res_data(res_data), .res_flags(res_flags), .result(result), .flags(flags),
        .busy(busy), .timeout_err(timeout_err), .op_count(op_count)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [N-1:0] a; logic [N-1:0] b; logic [3:0] mode; } issue_t;
    typedef struct { logic [N-1:0] res; logic [3:0] flg; logic [7:0] cnt; logic err; int lat; } done_t;

    int     exp_mode_q[$];
    issue_t exp_issue_q[$];
    done_t  exp_done_q[$];

    int nvec = 0, nmis = 0, cyc = 0;
    int m_mode, m_cnt;
    logic [N-1:0] m_res;
    logic [3:0]   m_flg;

    int           resp_delay = 1;
    bit           resp_never = 1'b1;
    bit           stall_en   = 1'b0;
    logic [N-1:0] resp_data  = '0;
    logic [3:0]   resp_flags = '0;

    logic       busy_p;
    logic [3:0] mode_p;
    int         h_cyc, lat_at;
    issue_t     mon_s;
    done_t      mon_d;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        nvec++;
        nmis++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: samples on the falling edge, compares against queued expectations.
    initial begin
        busy_p = 1'b0; mode_p = '0; h_cyc = -1; lat_at = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset !== 1'b1) begin
                busy_p = busy; mode_p = mode; h_cyc = -1; lat_at = -1;
            end else begin
                if (mode !== mode_p) begin
                    if (exp_mode_q.size() == 0) fail_now("mode_unexpected_change");
                    else chk("mode_step", int'(mode), exp_mode_q.pop_front());
                    mode_p = mode;
                end
                if (busy && !busy_p) lat_at = cyc + 1;
                if (cyc == lat_at) chk("start_to_op_valid", int'(op_valid), 1);
                if (op_valid && op_ready) begin
                    if (exp_issue_q.size() == 0) fail_now("unexpected_issue");
                    else begin
                        mon_s = exp_issue_q.pop_front();
                        chk("issue_A", int'(A), int'(mon_s.a));
                        chk("issue_B", int'(B), int'(mon_s.b));
                        chk("issue_mode", int'(mode), int'(mon_s.mode));
                        chk("issue_err_cleared", int'(timeout_err), 0);
                    end
                    h_cyc = cyc;
                end
                if (!busy && busy_p) begin
                    if (exp_done_q.size() == 0) fail_now("unexpected_completion");
                    else begin
                        mon_d = exp_done_q.pop_front();
                        chk("done_result", int'(result), int'(mon_d.res));
                        chk("done_flags", int'(flags), int'(mon_d.flg));
                        chk("done_op_count", int'(op_count), int'(mon_d.cnt));
                        chk("done_timeout_err", int'(timeout_err), int'(mon_d.err));
                        chk("done_latency", cyc - h_cyc, mon_d.lat);
                    end
                end
                busy_p = busy;
            end
        end
    end

    // ALU model: answers resp_delay cycles after the accepted request.
    initial begin
        res_valid = 1'b0; res_data = '0; res_flags = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && op_valid === 1'b1 && op_ready === 1'b1 && !resp_never) begin
                repeat (resp_delay) @(posedge clk);
                #1;
                res_valid = 1'b1; res_data = resp_data; res_flags = resp_flags;
                @(posedge clk);
                #1;
                res_valid = 1'b0; res_data = N'($urandom); res_flags = 4'($urandom);
            end
        end
    end

    initial begin
        op_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            op_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic sig(input int w);
        return (w == 0) ? busy : op_valid;
    endfunction

    task automatic wait_for(input int w, input logic val, input string name);
        int n = 0;
        while (sig(w) !== val && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) fail_now(name);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mode"}, int'(mode), 0);
        chk({tag, "_A"}, int'(A), 0);
        chk({tag, "_B"}, int'(B), 0);
        chk({tag, "_result"}, int'(result), 0);
        chk({tag, "_flags"}, int'(flags), 0);
        chk({tag, "_op_count"}, int'(op_count), 0);
        chk({tag, "_op_valid"}, int'(op_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_timeout_err"}, int'(timeout_err), 0);
    endtask

    task automatic press(input bit sel, input bit st, input int hold);
        if (sel) selector = 1'b0;
        if (st) start = 1'b0;
        tick(hold);
        selector = 1'b1;
        start = 1'b1;
        tick(12);
    endtask

    task automatic sel_press_idle();
        m_mode = (m_mode + 1) % NUM_MODES;
        exp_mode_q.push_back(m_mode);
        press(1'b1, 1'b0, 10);
    endtask

    task automatic bounce_press();
        m_mode = (m_mode + 1) % NUM_MODES;
        exp_mode_q.push_back(m_mode);
        selector = 1'b0; tick(1);
        selector = 1'b1; tick(1);
        selector = 1'b0; tick(1);
        selector = 1'b1; tick(1);
        selector = 1'b0; tick(10);
        selector = 1'b1; tick(12);
    endtask

    task automatic txn(input logic [N-1:0] a, input logic [N-1:0] b, input int d, input bit never,
                       input bit with_sel, input logic [N-1:0] data, input logic [3:0] flg);
        issue_t s;
        done_t  e;
        A_sw = a; B_sw = b;
        resp_delay = d; resp_never = never; resp_data = data; resp_flags = flg;
        s.a = a; s.b = b; s.mode = 4'(m_mode);
        exp_issue_q.push_back(s);
        if (never) begin
            e.err = 1'b1;
            e.lat = TIMEOUT + 1;
        end else begin
            m_res = data; m_flg = flg; m_cnt = (m_cnt + 1) % 256;
            e.err = 1'b0;
            e.lat = d + 2;
        end
        e.res = m_res; e.flg = m_flg; e.cnt = 8'(m_cnt);
        exp_done_q.push_back(e);
        press(with_sel, 1'b1, 10);
        wait_for(0, 1'b0, "wait_idle_timeout");
        tick(3);
    endtask

    task automatic sel_during_busy();
        issue_t s;
        done_t  e;
        A_sw = N'($urandom); B_sw = N'($urandom); resp_never = 1'b1;
        s.a = A_sw; s.b = B_sw; s.mode = 4'(m_mode);
        exp_issue_q.push_back(s);
        e.res = m_res; e.flg = m_flg; e.cnt = 8'(m_cnt); e.err = 1'b1; e.lat = TIMEOUT + 1;
        exp_done_q.push_back(e);
        start = 1'b0;
        wait_for(0, 1'b1, "wait_busy_timeout");
        start = 1'b1;
        press(1'b1, 1'b0, 10);
        wait_for(0, 1'b0, "wait_idle_timeout");
        tick(3);
    endtask

    task automatic rst_in_wait();
        issue_t s;
        A_sw = 4'h9; B_sw = 4'h6; resp_never = 1'b1; stall_en = 1'b0;
        s.a = A_sw; s.b = B_sw; s.mode = 4'(m_mode);
        exp_issue_q.push_back(s);
        start = 1'b0;
        wait_for(1, 1'b1, "wait_op_valid_timeout");
        wait_for(1, 1'b0, "wait_handshake_timeout");
        tick(4);
        start = 1'b1;
        chk("pre_reset_busy", int'(busy), 1);
        chk("pre_reset_op_count", int'(op_count), 1);
        #2 reset = 1'b0;
        #1 check_zero("midwait_rst");
        exp_done_q.delete();
        m_mode = 0; m_cnt = 0; m_res = '0; m_flg = '0;
        tick(3);
        check_zero("held_rst");
        reset = 1'b1;
        tick(12);
    endtask

    initial begin
        int r, d;
        reset = 1'b1; selector = 1'b1; start = 1'b1; A_sw = '0; B_sw = '0;
        m_mode = 0; m_cnt = 0; m_res = '0; m_flg = '0;
        #1 reset = 1'b0;
        #2 check_zero("async_rst");
        tick(3);
        check_zero("rst");
        reset = 1'b1;
        tick(3);

        for (int i = 0; i < 3; i++) sel_press_idle();
        txn(4'b0101, 4'b1100, 3, 1'b0, 1'b0, 4'b0001, 4'b0010);
        rst_in_wait();
        sel_during_busy();
        bounce_press();
        txn(4'h3, 4'hA, 1, 1'b1, 1'b0, 4'h7, 4'h1);
        txn(4'hF, 4'h1, 5, 1'b0, 1'b0, 4'hE, 4'h8);
        txn(4'h2, 4'h2, TIMEOUT, 1'b0, 1'b0, 4'hB, 4'h4);
        for (int i = 0; i < 10; i++) sel_press_idle();
        txn(4'h8, 4'h7, 2, 1'b0, 1'b1, 4'h5, 4'hC);

        for (int i = 0; i < 30; i++) begin
            stall_en = ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 9);
            if (r <= 2) sel_press_idle();
            else if (r == 3) bounce_press();
            else if (r == 4) sel_during_busy();
            else begin
                d = $urandom_range(1, 20);
                txn(N'($urandom), N'($urandom), d, d > TIMEOUT, r == 9, N'($urandom), 4'($urandom));
            end
        end
        stall_en = 1'b0;

        tick(20);
        chk("mode_queue_drained", exp_mode_q.size(), 0);
        chk("issue_queue_drained", exp_issue_q.size(), 0);
        chk("done_queue_drained", exp_done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/alu_op_controller.md
ALU_OP_CONTROLLER -- requirements
Module: alu_op_controller

Interface
REQ-001 SHALL have parameter N, default 4, meaning operand/result width in bits.
REQ-002 SHALL have parameter NUM_MODES, default 10, meaning number of ALU operation modes.
REQ-003 SHALL have parameter DEBOUNCE, default 4, meaning the number of consecutive stable cycles required to accept a button level.
REQ-004 SHALL have parameter TIMEOUT, default 16, meaning the maximum WAIT cycles before abort.
REQ-005 Ports (name  direction  width  meaning), one clock, reset asynchronous active-low:
 clk  in  1  system clock, rising edge
 reset  in  1  asynchronous active-low reset
 selector  in  1  raw mode pushbutton, active-low
 start  in  1  raw start pushbutton, active-low
 A_sw  in  N  operand A switches
 B_sw  in  N  operand B switches
 mode  out  4  current ALU mode
 A  out  N  latched operand A
 B  out  N  latched operand B
 op_valid  out  1  operation request to ALU
 op_ready  in  1  ALU accepts request
 res_valid  in  1  ALU result strobe
 res_data  in  N  ALU result
 res_flags  in  4  ALU flags {N,Z,C,V}
 result  out  N  captured result
 flags  out  4  captured flags
 busy  out  1  FSM not in IDLE
 timeout_err  out  1  sticky abort indicator
 op_count  out  8  completed-operation counter

Function
REQ-006 Each of selector and start SHALL pass through a 2-flop synchronizer and then a debouncer that changes its level only after DEBOUNCE consecutive cycles of the new synchronized level.
REQ-007 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; holding a button SHALL yield one event only.
REQ-008 The FSM SHALL have states IDLE, LATCH, ISSUE, WAIT, SHOW.
REQ-009 In IDLE, a selector event SHALL increment mode, wrapping from NUM_MODES-1 to 0.
REQ-010 In IDLE, a start event SHALL move the FSM to LATCH; if start and selector events coincide, start SHALL win and mode SHALL be unchanged.
REQ-011 Selector and start events outside IDLE SHALL be discarded and never queued.
REQ-012 LATCH SHALL capture A_sw into A and B_sw into B, then go to ISSUE after one cycle.
REQ-013 In ISSUE, op_valid SHALL be high; A, B and mode SHALL be stable; on op_valid&&op_ready the FSM SHALL go to WAIT, and op_valid SHALL deassert the next cycle.
REQ-014 In WAIT, a 1-cycle res_valid SHALL load res_data into result and res_flags into flags, and the FSM SHALL go to SHOW.
REQ-015 In WAIT, after TIMEOUT cycles without res_valid, the controller SHALL set timeout_err, leave result and flags unchanged, and return to IDLE.
REQ-016 If res_valid arrives in the expiring WAIT cycle, the result SHALL win and timeout_err SHALL not be set.
REQ-017 SHOW SHALL last one cycle, increment op_count (wrapping 255->0), and return to IDLE.
REQ-018 Any subsequent start event SHALL clear timeout_err.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 Latency from a start event to op_valid SHALL be 2 cycles (LATCH, then ISSUE).

Reset
REQ-021 On reset low, the controller SHALL go to IDLE immediately, regardless of clock.
REQ-022 While reset is low, all outputs SHALL be 0: mode, A, B, result, flags, op_count, op_valid, busy and timeout_err.
REQ-023 While reset is low, debouncers SHALL hold the released level (1) and synchronizers SHALL be set to 1.
REQ-024 Reset asserted mid-operation SHALL drop op_valid immediately, and no partial result SHALL be retained.

Verification
REQ-025 Three clean selector presses (each held 10 cycles), DEBOUNCE=4 -> mode 0->1->2->3, one increment per press.
REQ-026 Selector bouncing 1-0-1-0 at 1-cycle intervals, then held low 10 cycles -> exactly one increment.
REQ-027 Ten presses with NUM_MODES=10 -> mode returns to 0.
REQ-028 A_sw=0101, B_sw=1100, start press, op_ready=1, res_valid after 3 cycles with res_data=0001 and res_flags=0010 -> A=0101, B=1100, result=0001, flags=0010, op_count=1, busy low after SHOW.
REQ-029 Start press with res_valid never asserted -> timeout_err=1 after 16 WAIT cycles, busy=0, op_count unchanged; next start clears timeout_err.
REQ-030 Reset pulsed low during WAIT with op_count=1 -> all outputs 0 asynchronously; a selector press during busy leaves mode unchanged.
